// File: rtl/uart_duplex.sv
// uart_duplex: full-duplex UART with independent TX and RX engines on one clock.
// Ports:
//   clk, rst_n         system clock (rising edge), async active-low reset
//   rx / tx            serial pads, both idle high; rx is synchronised internally
//   tx_data/valid/ready  TX byte handshake, transfer when tx_valid && tx_ready
//   tx_busy            TX frame in progress
//   rx_data/rx_valid   received payload, rx_valid is a one-cycle pulse
//   rx_parity_err/rx_frame_err  status of the last received frame
//   rx_busy            RX frame in progress
module uart_duplex #(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned STOP_LEN     = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CW           = $clog2(STOP_LEN + 1);
  localparam int unsigned BW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] STOP_M1 = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          PAR_EN  = 1'(PARITY != 0);
  localparam logic          PAR_ODD = 1'(PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_e;

  // ---------------- TX engine ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d, tx_ready_q, tx_ready_d, tx_busy_q, tx_busy_d;
  logic                 tx_accept;

  assign tx_accept = tx_valid && tx_ready_q;

  // TX state, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // TX next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_accept) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
        end
      end
      TX_START: if (tx_cnt_q == CPB_M1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == CPB_M1) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_BIT) tx_state_d = PAR_EN ? TX_PAR : TX_STOP;
        else                      tx_bit_d   = tx_bit_q + BW'(1);
      end
      TX_PAR: if (tx_cnt_q == CPB_M1) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == STOP_M1) begin
        // ready is already high here, so a waiting byte chains with no idle gap
        tx_cnt_d = '0;
        if (tx_accept) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
      end
    endcase
  end

  // TX outputs, registered from the next state
  always_comb begin
    tx_d = 1'b1;
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      TX_PAR:   tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE) ||
                 ((tx_state_d == TX_STOP) && (tx_cnt_d == STOP_M1));
    tx_busy_d  = (tx_state_d != TX_IDLE);
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

  // ---------------- RX engine ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d, rx_busy_q, rx_busy_d;
  logic                 rx_stop_hit;

  assign rx_stop_hit = (rx_state_q == RX_STOP) && (rx_cnt_q == CPB_M1);

  // RX synchroniser, state, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_busy_q  <= rx_busy_d;
    end
  end

  // RX next state
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        // a line back high at mid-start is a glitch, not a frame
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CPB_M1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = PAR_EN ? RX_PAR : RX_STOP;
        else                      rx_bit_d   = rx_bit_q + BW'(1);
      end
      RX_PAR: if (rx_cnt_q == CPB_M1) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_sync_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CPB_M1) begin
        // leave at mid-stop so the next start edge is not missed
        rx_cnt_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // RX outputs: result and flags update together with the valid pulse
  always_comb begin
    rx_valid_d = rx_stop_hit;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_stop_hit) begin
      rx_data_d = rx_shift_q;
      rx_perr_d = PAR_EN && ((^rx_shift_q) ^ rx_par_q ^ PAR_ODD);
      rx_ferr_d = !rx_sync_q;
    end
    rx_busy_d = (rx_state_d != RX_IDLE);
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_duplex.sv
// tb_uart_duplex: directed bench for uart_duplex. Instance a uses defaults
// (8N1), instance b uses even parity for the parity scenarios.
module tb_uart_duplex;

  localparam int CPB   = 12000000 / 115200;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, tx_a, tx_valid_a, tx_ready_a, tx_busy_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       rx_valid_a, rx_perr_a, rx_ferr_a, rx_busy_a;
  logic       rx_b, tx_b, tx_valid_b, tx_ready_b, tx_busy_b;
  logic [7:0] tx_data_b, rx_data_b;
  logic       rx_valid_b, rx_perr_b, rx_ferr_b, rx_busy_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int va_cnt = 0;
  int vb_cnt = 0;
  int va_cyc = 0;

  always #5 clk = ~clk;

  uart_duplex u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_busy(tx_busy_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_parity_err(rx_perr_a),
    .rx_frame_err(rx_ferr_a), .rx_busy(rx_busy_a)
  );

  uart_duplex #(.PARITY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .tx(tx_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_busy(tx_busy_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_parity_err(rx_perr_b),
    .rx_frame_err(rx_ferr_b), .rx_busy(rx_busy_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // count rx_valid pulses away from the active edge
  always @(negedge clk) begin
    if (rx_valid_a === 1'b1) begin va_cnt = va_cnt + 1; va_cyc = cyc; end
    if (rx_valid_b === 1'b1) vb_cnt = vb_cnt + 1;
  end

  // expected tx level for an 8N1 frame at cycle pos (0 = first start-bit cycle)
  function automatic logic exp_tx(input logic [7:0] d, input int pos);
    int b;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // drive n line bits (LSB first) on rx_a or rx_b; call at a negedge
  task automatic drive_rx(input bit sel_b, input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel_b) rx_b = bits[i]; else rx_a = bits[i];
      repeat (CPB) @(negedge clk);
    end
    if (sel_b) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  // send one byte on instance a and count tx mismatches against the model
  task automatic run_tx_frame(input logic [7:0] d, output int bad);
    tx_data_a = d; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0; tx_data_a = ~d;
    bad = 0;
    for (int c = 1; c <= FRAME; c++) begin
      if (c > 1) @(negedge clk);
      if (tx_a !== exp_tx(d, c - 1)) bad++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({tx_a, tx_ready_a, tx_busy_a} !== 3'b110) begin errors++;
      $display("FAIL reset_tx: got %b expected 110", {tx_a, tx_ready_a, tx_busy_a}); end
    checks++; if ({rx_data_a, rx_valid_a, rx_perr_a, rx_ferr_a, rx_busy_a} !== 12'h000) begin errors++;
      $display("FAIL reset_rx: got %h expected 000", {rx_data_a, rx_valid_a, rx_perr_a, rx_ferr_a, rx_busy_a}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if ({tx_a, tx_ready_a, tx_busy_a, rx_busy_a} !== 4'b1100) begin errors++;
      $display("FAIL idle_after_reset: got %b expected 1100", {tx_a, tx_ready_a, tx_busy_a, rx_busy_a}); end
  endtask

  task automatic test_tx_frame;
    int bad, first;
    tx_data_a = 8'hA5; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0; tx_data_a = 8'h00;
    bad = 0; first = -1;
    for (int c = 1; c <= FRAME; c++) begin
      if (c > 1) @(negedge clk);
      if (tx_a !== exp_tx(8'hA5, c - 1)) begin bad++; if (first < 0) first = c; end
      if (c == 1) begin
        checks++; if ({tx_ready_a, tx_busy_a} !== 2'b01) begin errors++;
          $display("FAIL tx_accept_flags: got %b expected 01", {tx_ready_a, tx_busy_a}); end
      end
      if (c == FRAME - 1) begin
        checks++; if (tx_ready_a !== 1'b0) begin errors++;
          $display("FAIL tx_ready_early: got %b expected 0", tx_ready_a); end
      end
      if (c == FRAME) begin
        checks++; if ({tx_ready_a, tx_busy_a} !== 2'b11) begin errors++;
          $display("FAIL tx_ready_last_stop: got %b expected 11", {tx_ready_a, tx_busy_a}); end
      end
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL tx_a5_waveform: %0d bad cycles (first %0d) expected 0", bad, first); end
    @(negedge clk);
    checks++; if ({tx_a, tx_ready_a, tx_busy_a} !== 3'b110) begin errors++;
      $display("FAIL tx_idle_after: got %b expected 110", {tx_a, tx_ready_a, tx_busy_a}); end
  endtask

  task automatic test_back_to_back;
    int bad, first, pos;
    logic [7:0] d;
    tx_data_a = 8'h00; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_data_a = 8'hFF;
    bad = 0; first = -1;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      if (c > 1) @(negedge clk);
      if (c == FRAME + 1) tx_valid_a = 1'b0;
      d   = ((c - 1) < FRAME) ? 8'h00 : 8'hFF;
      pos = (c - 1) % FRAME;
      if (tx_a !== exp_tx(d, pos)) begin bad++; if (first < 0) first = c; end
      if (c == FRAME + 1) begin
        checks++; if ({tx_a, tx_ready_a, tx_busy_a} !== 3'b001) begin errors++;
          $display("FAIL b2b_second_start: got %b expected 001", {tx_a, tx_ready_a, tx_busy_a}); end
      end
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL b2b_waveform: %0d bad cycles (first %0d) expected 0", bad, first); end
    checks++; if (tx_ready_a !== 1'b1) begin errors++;
      $display("FAIL b2b_ready_end: got %b expected 1", tx_ready_a); end
    @(negedge clk);
    checks++; if ({tx_a, tx_busy_a} !== 2'b10) begin errors++;
      $display("FAIL b2b_idle: got %b expected 10", {tx_a, tx_busy_a}); end
  endtask

  task automatic test_rx_frame;
    int n0, t0, dt;
    n0 = va_cnt; t0 = cyc;
    drive_rx(1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (4) @(negedge clk);
    dt = va_cyc - t0;
    checks++; if (va_cnt !== n0 + 1) begin errors++;
      $display("FAIL rx_3c_count: got %0d expected %0d", va_cnt - n0, 1); end
    checks++; if ({rx_data_a, rx_perr_a, rx_ferr_a} !== {8'h3C, 2'b00}) begin errors++;
      $display("FAIL rx_3c_data: got %h/%b%b expected 3c/00", rx_data_a, rx_perr_a, rx_ferr_a); end
    checks++; if (dt < 985 || dt > 997) begin errors++;
      $display("FAIL rx_3c_latency: got %0d cycles expected 985..997", dt); end
  endtask

  task automatic test_parity;
    int n0;
    n0 = vb_cnt;
    drive_rx(1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    checks++; if (vb_cnt !== n0 + 1) begin errors++;
      $display("FAIL par_bad_count: got %0d expected 1", vb_cnt - n0); end
    checks++; if ({rx_data_b, rx_perr_b, rx_ferr_b} !== {8'h07, 2'b10}) begin errors++;
      $display("FAIL par_bad_flags: got %h/%b%b expected 07/10", rx_data_b, rx_perr_b, rx_ferr_b); end
    drive_rx(1'b1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    checks++; if (vb_cnt !== n0 + 2) begin errors++;
      $display("FAIL par_good_count: got %0d expected 2", vb_cnt - n0); end
    checks++; if ({rx_data_b, rx_perr_b, rx_ferr_b} !== {8'h07, 2'b00}) begin errors++;
      $display("FAIL par_good_flags: got %h/%b%b expected 07/00", rx_data_b, rx_perr_b, rx_ferr_b); end
  endtask

  task automatic test_glitch_and_break;
    int n0;
    n0 = va_cnt;
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_busy_a !== 1'b1) begin errors++;
      $display("FAIL glitch_busy: got %b expected 1", rx_busy_a); end
    repeat (200) @(negedge clk);
    checks++; if ({rx_busy_a, 32'(va_cnt - n0)} !== {1'b0, 32'd0}) begin errors++;
      $display("FAIL glitch_ignored: busy %b pulses %0d expected 0/0", rx_busy_a, va_cnt - n0); end
    rx_a = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    checks++; if (va_cnt !== n0 + 1) begin errors++;
      $display("FAIL break_count: got %0d expected 1", va_cnt - n0); end
    checks++; if ({rx_data_a, rx_perr_a, rx_ferr_a, rx_busy_a} !== {8'h00, 3'b011}) begin errors++;
      $display("FAIL break_flags: got %h/%b%b%b expected 00/011", rx_data_a, rx_perr_a, rx_ferr_a, rx_busy_a); end
    rx_a = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if ({rx_busy_a, 32'(va_cnt - n0)} !== {1'b0, 32'd1}) begin errors++;
      $display("FAIL break_release: busy %b pulses %0d expected 0/1", rx_busy_a, va_cnt - n0); end
  endtask

  task automatic test_full_duplex;
    int bad, n0;
    logic [9:0] fr;
    n0 = va_cnt;
    fork
      run_tx_frame(8'h55, bad);
      drive_rx(1'b0, {2'b00, 1'b1, 8'hC3, 1'b0}, 10);
    join
    repeat (4) @(negedge clk);
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL duplex_tx_waveform: %0d bad cycles expected 0", bad); end
    checks++; if ({rx_data_a, rx_perr_a, rx_ferr_a, 32'(va_cnt - n0)} !== {8'hC3, 2'b00, 32'd1}) begin errors++;
      $display("FAIL duplex_rx: got %h/%b%b pulses %0d expected c3/00/1", rx_data_a, rx_perr_a, rx_ferr_a, va_cnt - n0); end
    // repeat run, reset lands mid-frame on both engines
    fr = {1'b1, 8'hC3, 1'b0};
    n0 = va_cnt;
    for (int c = 0; c < 500; c++) begin
      if (c == 0) begin tx_data_a = 8'h55; tx_valid_a = 1'b1; end
      if (c == 1) tx_valid_a = 1'b0;
      rx_a = fr[c / CPB];
      @(negedge clk);
    end
    checks++; if ({tx_a, tx_busy_a, rx_busy_a} !== 3'b011) begin errors++;
      $display("FAIL pre_reset_midframe: got %b expected 011", {tx_a, tx_busy_a, rx_busy_a}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({tx_a, tx_ready_a, tx_busy_a} !== 3'b110) begin errors++;
      $display("FAIL midframe_reset_tx: got %b expected 110", {tx_a, tx_ready_a, tx_busy_a}); end
    checks++; if ({rx_data_a, rx_valid_a, rx_perr_a, rx_ferr_a, rx_busy_a} !== 12'h000) begin errors++;
      $display("FAIL midframe_reset_rx: got %h expected 000", {rx_data_a, rx_valid_a, rx_perr_a, rx_ferr_a, rx_busy_a}); end
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (1300) @(negedge clk);
    checks++; if ({tx_a, tx_busy_a, rx_busy_a, 32'(va_cnt - n0)} !== {3'b100, 32'd0}) begin errors++;
      $display("FAIL after_midframe_reset: got %b pulses %0d expected 100/0", {tx_a, tx_busy_a, rx_busy_a}, va_cnt - n0); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a = 1'b1; tx_data_a = 8'h00; tx_valid_a = 1'b0;
    rx_b = 1'b1; tx_data_b = 8'h00; tx_valid_b = 1'b0;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx_frame();
    test_parity();
    test_glitch_and_break();
    test_full_duplex();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_duplex.md
Name: uart_duplex

Overview:
Parametrised full-duplex UART for the icestick designs: independent RX and TX engines sharing one clock, so receive and transmit may run simultaneously. Configurable data width, parity and stop bits. Valid/ready handshake on TX. RX reports framing and parity errors. Sits between the pin-level rx/tx pads and the byte-level control logic.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; 1 or 2
Derived: CLKS_PER_BIT = CLK_HZ / BAUD (integer truncation; 104 at defaults); HALF_BIT = CLKS_PER_BIT / 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous to clk, idle high
tx  out  1  serial output, idle high
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX engine can accept; transfer when tx_valid && tx_ready
tx_busy  out  1  frame in progress on tx
rx_data  out  DATA_BITS  last received payload
rx_valid  out  1  one-cycle pulse, rx_data/error flags updated
rx_parity_err  out  1  parity mismatch on last frame (0 when PARITY=0)
rx_frame_err  out  1  first stop bit sampled low on last frame
rx_busy  out  1  frame reception in progress

Behaviour:
- Reset (async, rst_n=0): tx=1, tx_ready=1, tx_busy=0, rx_data=0, rx_valid=0, both error flags 0, rx_busy=0, rx synchroniser flops=1, both FSMs to IDLE, counters 0. Reset mid-frame aborts both frames; tx goes high immediately, no rx_valid.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- TX accept: in IDLE, tx_ready=1; on tx_valid && tx_ready, latch tx_data; the next cycle tx=0, tx_ready=0, tx_busy=1. Later tx_data changes are ignored.
- Each start/data/parity bit is held exactly CLKS_PER_BIT cycles. Data is sent LSB first.
- Parity bit = XOR of the payload for even parity, inverted XOR for odd parity.
- Stop: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the last stop cycle, tx_ready rises (tx_busy falls next cycle). This allows back-to-back frames with no idle gap.
- Frame length at defaults: 10*104 = 1040 cycles.
- RX input: 2-flop synchroniser on rx; all RX logic uses the synchronised value (2-cycle input latency).
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE, plus BREAK.
- IDLE: synced rx==0 -> START, counter cleared, rx_busy=1.
- START: at HALF_BIT, re-sample rx. If high, treat as a glitch: return to IDLE, no outputs. If low, go to DATA.
- Sampling: each following bit is sampled once every CLKS_PER_BIT cycles (mid-bit). Data is shifted in LSB first.
- STOP: the first stop bit is sampled at mid-bit. In that same cycle, rx_data, rx_parity_err and rx_frame_err are updated and rx_valid pulses high for 1 cycle.
  - If the stop sample is 1: go to IDLE immediately, so a new start edge is detectable within half a bit.
  - If the stop sample is 0: set rx_frame_err, go to BREAK; stay there until synced rx==1, then go to IDLE.
- A second stop bit is not checked by RX.
- Error flags hold until the next rx_valid.
- No RX buffering and no backpressure: the consumer must capture data on the rx_valid pulse.
- TX and RX are fully independent. Simultaneous TX accept and RX start in the same cycle are both honoured.
- Counter width: $clog2(STOP_BITS*CLKS_PER_BIT+1) bits. Counters reset to 0 at every bit boundary and never wrap mid-bit.

Test Plan:
- Defaults, send tx_data=8'hA5 with one-cycle tx_valid -> tx low on cycle +1, then bits 1,0,1,0,0,1,0,1 at 104-cycle spacing, stop high; tx_ready high again 1040 cycles after accept.
- Two tx_valid bursts back-to-back (8'h00 then 8'hFF) with tx_valid held -> second start bit begins the cycle after the first stop bit ends; no idle gap; total 2080 cycles.
- Drive rx with frame 8'h3C at 115200 -> rx_valid pulses once about 9.5 bit-times (+2 cycles) after the falling edge; rx_data=8'h3C, both error flags 0.
- PARITY=2: receive 8'h07 with parity bit 0 (wrong) -> rx_valid with rx_parity_err=1. Next frame 8'h07 with parity 1 -> rx_parity_err=0.
- rx low pulse of 20 cycles -> no rx_valid and RX returns to IDLE. Then rx held low for 2 frame times (break) -> one rx_valid with rx_data=0, rx_frame_err=1, no further frames until rx returns high.
- Full duplex: transmit 8'h55 while receiving 8'hC3 overlapped; assert rst_n=0 mid-frame on a repeat run -> first run gives correct tx waveform and rx_data=8'hC3. In the repeat run, reset makes tx=1 immediately and outputs equal their reset values, with no rx_valid.
